// File: rtl/centroid_crosshair_overlay.sv
// Crosshair overlay stage: marks the previous frame's centroid on the current
// frame of a 24-bit RGB AXI-Stream. The output is a 1-deep register slice.
module centroid_crosshair_overlay #(
    parameter int          IMG_WIDTH  = 640,
    parameter int          IMG_HEIGHT = 480,
    parameter int          ARM_LEN    = 8,
    parameter logic [23:0] MARK_COLOR = 24'hFF00FF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [23:0] i_tdata,
    input  logic        i_tuser,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        o_tready,
    output logic [23:0] o_tdata,
    output logic        o_tuser,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        i_tready,
    input  logic [9:0]  i_centroid_x,
    input  logic [8:0]  i_centroid_y,
    input  logic        i_red_object_valid,
    input  logic        i_end_frame,
    input  logic        i_overlay_en,
    output logic        o_active_valid
);

    localparam int XW  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    // Distances are one bit wider than the wider operand so they never wrap.
    localparam int DXW = ((XW > 10) ? XW : 10) + 1;
    localparam int DYW = ((YW > 9)  ? YW : 9)  + 1;

    localparam logic [XW-1:0]  X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]  Y_LAST = YW'(IMG_HEIGHT - 1);
    localparam logic [XW-1:0]  X_ONE  = XW'(1);
    localparam logic [YW-1:0]  Y_ONE  = YW'(1);
    localparam logic [DXW-1:0] ARM_DX = DXW'(ARM_LEN);
    localparam logic [DYW-1:0] ARM_DY = DYW'(ARM_LEN);

    typedef struct packed {
        logic       valid;
        logic [9:0] x;
        logic [8:0] y;
    } meta_t;

    logic [23:0]    tdata_q;
    logic           tuser_q, tlast_q, tvalid_q;
    logic [XW-1:0]  x_q, x_d, cur_x;
    logic [YW-1:0]  y_q, y_d, cur_y;
    meta_t          pend_q, pend_d, act_q, act_d, in_meta;
    logic           pend_full_q, pend_full_d;
    logic           fire, sof_fire;
    logic [DXW-1:0] px_ext, cx_ext, dx;
    logic [DYW-1:0] py_ext, cy_ext, dy;
    logic           hit;
    logic [23:0]    pix_d;

    assign o_tready = i_tready || !tvalid_q;
    assign fire     = i_tvalid && o_tready;
    assign sof_fire = fire && i_tuser;
    assign in_meta  = {i_red_object_valid, i_centroid_x, i_centroid_y};

    // Raster position of the offered beat and of the beat after it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cur_x = i_tuser ? '0 : x_q;
        cur_y = i_tuser ? '0 : y_q;
        x_d   = x_q;
        y_d   = y_q;
        if (fire) begin
            if (cur_x == X_LAST) begin
                x_d = '0;
                y_d = (cur_y == Y_LAST) ? '0 : cur_y + Y_ONE;
            end else begin
                x_d = cur_x + X_ONE;
                y_d = cur_y;
            end
        end
    end

    // Metadata double buffer: publish into pending, promote to active at start of frame.
    always_comb begin
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        act_d       = act_q;
        if (i_end_frame) begin
            pend_d      = in_meta;
            pend_full_d = 1'b1;
        end
        if (sof_fire) begin
            if (i_end_frame) begin
                act_d       = in_meta;
                pend_full_d = 1'b0;
            end else if (pend_full_q) begin
                act_d       = pend_q;
                pend_full_d = 1'b0;
            end
        end
    end

    // Crosshair hit test; act_d already reflects a promotion on the start-of-frame beat.
    always_comb begin
        px_ext = DXW'(cur_x);
        cx_ext = DXW'(act_d.x);
        py_ext = DYW'(cur_y);
        cy_ext = DYW'(act_d.y);
        dx     = (px_ext >= cx_ext) ? px_ext - cx_ext : cx_ext - px_ext;
        dy     = (py_ext >= cy_ext) ? py_ext - cy_ext : cy_ext - py_ext;
        hit    = ((px_ext == cx_ext) && (dy <= ARM_DY)) ||
                 ((py_ext == cy_ext) && (dx <= ARM_DX));
        pix_d  = (i_overlay_en && act_d.valid && hit) ? MARK_COLOR : i_tdata;
    end

    // Output slice, raster counters and metadata registers.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) begin
            tvalid_q    <= 1'b0;
            tdata_q     <= '0;
            tuser_q     <= 1'b0;
            tlast_q     <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            act_q       <= '0;
        end else begin
            if (o_tready) begin
                tvalid_q <= i_tvalid;
                if (i_tvalid) begin
                    tdata_q <= pix_d;
                    tuser_q <= i_tuser;
                    tlast_q <= i_tlast;
                end
            end
            x_q         <= x_d;
            y_q         <= y_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            act_q       <= act_d;
        end
    end

    assign o_tdata        = tdata_q;
    assign o_tuser        = tuser_q;
    assign o_tlast        = tlast_q;
    assign o_tvalid       = tvalid_q;
    assign o_active_valid = act_q.valid;

endmodule

// File: tb/tb_centroid_crosshair_overlay.sv
// Scoreboard bench for centroid_crosshair_overlay on a reduced 40x30 raster.
module tb_centroid_crosshair_overlay;

    localparam int          W    = 40;
    localparam int          H    = 30;
    localparam int          ARM  = 8;
    localparam logic [23:0] MARK = 24'hFF00FF;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [23:0] i_tdata = '0;
    logic        i_tuser = 1'b0, i_tlast = 1'b0, i_tvalid = 1'b0;
    logic        o_tready;
    logic [23:0] o_tdata;
    logic        o_tuser, o_tlast, o_tvalid;
    logic        i_tready = 1'b1;
    logic [9:0]  i_centroid_x = '0;
    logic [8:0]  i_centroid_y = '0;
    logic        i_red_object_valid = 1'b0, i_end_frame = 1'b0, i_overlay_en = 1'b1;
    logic        o_active_valid;

    centroid_crosshair_overlay #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .ARM_LEN(ARM), .MARK_COLOR(MARK)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
        .o_tready(o_tready),
        .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
        .i_tready(i_tready),
        .i_centroid_x(i_centroid_x), .i_centroid_y(i_centroid_y),
        .i_red_object_valid(i_red_object_valid), .i_end_frame(i_end_frame),
        .i_overlay_en(i_overlay_en), .o_active_valid(o_active_valid)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [23:0] d;
        logic        u;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_miscmp = 0;
    int    ready_pct = 100;
    int    mark_cnt = 0;

    // Reference model state: frame-relative beat index and marker buffers.
    int m_n = 0;
    bit m_act_v = 0, m_pend_v = 0, m_pfull = 0;
    int m_act_x = 0, m_act_y = 0, m_pend_x = 0, m_pend_y = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies the clock edge that follows to the model; pushes the expected beat on a fire.
    task automatic model_edge(input bit fired);
        int x, y, ax, ay;
        bit hit;
        beat_t b;
        if (fired && i_tuser) begin
            m_n = 0;
            if (i_end_frame) begin
                m_act_v = i_red_object_valid;
                m_act_x = int'(i_centroid_x);
                m_act_y = int'(i_centroid_y);
                m_pfull = 0;
            end else if (m_pfull) begin
                m_act_v = m_pend_v; m_act_x = m_pend_x; m_act_y = m_pend_y;
                m_pfull = 0;
            end
        end else if (i_end_frame) begin
            m_pend_v = i_red_object_valid;
            m_pend_x = int'(i_centroid_x);
            m_pend_y = int'(i_centroid_y);
            m_pfull  = 1;
        end
        if (fired) begin
            x   = m_n % W;
            y   = (m_n / W) % H;
            ax  = (x > m_act_x) ? x - m_act_x : m_act_x - x;
            ay  = (y > m_act_y) ? y - m_act_y : m_act_y - y;
            hit = ((x == m_act_x) && (ay <= ARM)) || ((y == m_act_y) && (ax <= ARM));
            b.d = (i_overlay_en && m_act_v && hit) ? MARK : i_tdata;
            b.u = i_tuser;
            b.l = i_tlast;
            exp_q.push_back(b);
            m_n++;
        end
    endtask

    task automatic do_reset_mid();
        i_tvalid    = 1'b0;
        i_end_frame = 1'b0;
        i_rst       = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        m_n = 0; m_act_v = 0; m_act_x = 0; m_act_y = 0;
        m_pend_v = 0; m_pend_x = 0; m_pend_y = 0; m_pfull = 0;
        exp_q.delete();
        check("rst_mid_tvalid", {31'd0, o_tvalid}, 32'd0);
        check("rst_mid_active", {31'd0, o_active_valid}, 32'd0);
    endtask

    task automatic drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 2000) begin
            @(posedge i_clk); #1;
            c++;
        end
        check("drain_left", exp_q.size(), 32'd0);
    endtask

    task automatic send_frame(input int pub_beat, input bit pv, input int px, input int py,
                              input int valid_pct, input int en_pct, input bit const_pix,
                              input int rst_beat);
        logic [31:0] r;
        int cnt;
        bit fired;
        mark_cnt = 0;
        for (int k = 0; k < W * H; k++) begin
            if (k == rst_beat) do_reset_mid();
            while ($urandom_range(99) >= valid_pct) begin
                i_tvalid = 1'b0;
                @(posedge i_clk); #1;
            end
            r            = $urandom();
            i_tvalid     = 1'b1;
            // Bit 8 forced high keeps random pixels distinct from the marker colour.
            i_tdata      = const_pix ? 24'h102030 : (r[23:0] | 24'h000100);
            i_tuser      = (k == 0);
            i_tlast      = ((k % W) == W - 1);
            i_overlay_en = ($urandom_range(99) < en_pct);
            r            = $urandom();
            i_centroid_x = r[9:0];
            i_centroid_y = r[18:10];
            i_red_object_valid = r[19];
            if (k == pub_beat) begin
                i_end_frame        = 1'b1;
                i_centroid_x       = 10'(px);
                i_centroid_y       = 9'(py);
                i_red_object_valid = pv;
            end
            cnt = 0;
            forever begin
                @(negedge i_clk);
                fired = o_tready;
                model_edge(fired);
                @(posedge i_clk); #1;
                i_end_frame = 1'b0;
                if (fired) break;
                cnt++;
                if (cnt > 500) begin
                    $display("FAIL accept_timeout: beat %0d never accepted", k);
                    $fatal(1);
                end
            end
        end
        i_tvalid = 1'b0;
        i_tuser  = 1'b0;
        drain();
    endtask

    // Randomised downstream ready.
    initial begin
        forever begin
            @(posedge i_clk); #1;
            i_tready = ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor: pops the scoreboard on each output transfer and checks stall stability.
    initial begin
        beat_t e;
        bit prev_stall = 0;
        logic [23:0] h_d;
        logic h_u, h_l;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("hold_tvalid", {31'd0, o_tvalid}, 32'd1);
                    check("hold_tdata", {8'd0, o_tdata}, {8'd0, h_d});
                    check("hold_flags", {30'd0, o_tuser, o_tlast}, {30'd0, h_u, h_l});
                end
                if (o_tvalid && i_tready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_miscmp++;
                        $display("FAIL extra_beat: got data %h with no beat expected", o_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("tdata", {8'd0, o_tdata}, {8'd0, e.d});
                        check("tuser", {31'd0, o_tuser}, {31'd0, e.u});
                        check("tlast", {31'd0, o_tlast}, {31'd0, e.l});
                        if (o_tdata == MARK) mark_cnt++;
                    end
                end
                prev_stall = o_tvalid && !i_tready;
                h_d = o_tdata; h_u = o_tuser; h_l = o_tlast;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("rst_tvalid", {31'd0, o_tvalid}, 32'd0);
        check("rst_tdata", {8'd0, o_tdata}, 32'd0);
        check("rst_flags", {30'd0, o_tuser, o_tlast}, 32'd0);
        check("rst_active", {31'd0, o_active_valid}, 32'd0);

        // Plain pass-through, constant pixel, nothing armed.
        send_frame(-1, 0, 0, 0, 100, 100, 1, -1);
        check("f1_marks", mark_cnt, 0);
        check("f1_active", {31'd0, o_active_valid}, 32'd0);

        // Publish mid-frame: this frame unchanged, next frames carry the marker.
        send_frame(600, 1, 20, 15, 100, 100, 0, -1);
        check("f2_marks", mark_cnt, 0);
        check("f2_active", {31'd0, o_active_valid}, 32'd0);
        send_frame(-1, 0, 0, 0, 100, 100, 0, -1);
        check("f3_marks", mark_cnt, 33);
        check("f3_active", {31'd0, o_active_valid}, 32'd1);

        // Same marker under random valid and ready stalls.
        ready_pct = 30;
        send_frame(-1, 0, 0, 0, 50, 100, 0, -1);
        ready_pct = 100;
        check("f4_marks", mark_cnt, 33);

        // Overlay enable toggled per beat.
        send_frame(-1, 0, 0, 0, 100, 50, 0, -1);

        // Corner marker clips at the image edges.
        send_frame(900, 1, 2, 1, 100, 100, 0, -1);
        check("f6_marks", mark_cnt, 33);
        send_frame(-1, 0, 0, 0, 100, 100, 0, -1);
        check("f7_marks", mark_cnt, 20);

        // Publish coincident with the start-of-frame beat takes effect immediately.
        send_frame(0, 1, 30, 20, 100, 100, 0, -1);
        check("f8_marks", mark_cnt, 33);

        // Out-of-range centroid marks nothing.
        send_frame(500, 1, 45, 40, 100, 100, 0, -1);
        check("f9_marks", mark_cnt, 33);
        send_frame(-1, 0, 0, 0, 100, 100, 0, -1);
        check("f10_marks", mark_cnt, 0);
        check("f10_active", {31'd0, o_active_valid}, 32'd1);

        // Publish with valid=0 disarms.
        send_frame(300, 0, 20, 15, 100, 100, 0, -1);
        send_frame(-1, 0, 0, 0, 100, 100, 0, -1);
        check("f12_marks", mark_cnt, 0);
        check("f12_active", {31'd0, o_active_valid}, 32'd0);

        // Arm, then reset at line 20 of the armed frame.
        send_frame(100, 1, 20, 15, 100, 100, 0, -1);
        send_frame(-1, 0, 0, 0, 100, 100, 0, 20 * W);
        check("f14_active", {31'd0, o_active_valid}, 32'd0);
        send_frame(-1, 0, 0, 0, 100, 100, 0, -1);
        check("f15_marks", mark_cnt, 0);
        check("f15_active", {31'd0, o_active_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/centroid_crosshair_overlay.md
Name: centroid_crosshair_overlay

Overview:
- Downstream of the centroid calculator. Consumes its per-frame metadata (centroid x/y, object-valid, end-frame pulse) and the 24-bit RGB video AXI-Stream.
- When an object was detected in the previous frame, draws a solid crosshair at that frame's centroid into the current frame.
- Re-emits the video through a 1-deep register slice toward the display/VDMA.

Parameters:
- IMG_WIDTH, 640, active pixels per line.
- IMG_HEIGHT, 480, active lines per frame.
- ARM_LEN, 8, crosshair half-length in pixels; each arm spans centroid ±ARM_LEN inclusive.
- MARK_COLOR, 24'hFF00FF, RGB value substituted on crosshair pixels.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_tdata  in  24  input RGB pixel.
- i_tuser  in  1  start-of-frame, on the first beat only.
- i_tlast  in  1  end-of-line.
- i_tvalid  in  1  input beat valid.
- o_tready  out  1  input beat accepted when high with i_tvalid.
- o_tdata  out  24  output RGB pixel, possibly overlaid.
- o_tuser  out  1  passed through.
- o_tlast  out  1  passed through.
- o_tvalid  out  1  output beat valid.
- i_tready  in  1  downstream ready.
- i_centroid_x  in  10  centroid column from the centroid calculator.
- i_centroid_y  in  9  centroid row.
- i_red_object_valid  in  1  object qualified in the frame being published.
- i_end_frame  in  1  1-cycle publish strobe; x/y/valid are sampled on it.
- i_overlay_en  in  1  0 = pure pass-through; evaluated per beat.
- o_active_valid  out  1  crosshair currently armed (debug).

Behaviour:
- Reset (i_rst=1 at a clock edge) forces:
  - o_tvalid=0, o_tuser=0, o_tlast=0, o_tdata=0, o_active_valid=0.
  - x/y counters = 0.
  - pending and active metadata cleared (valid=0, x=0, y=0).
  - Applies mid-frame too. No flush: pixels after reset are counted from (0,0) until the next i_tuser beat realigns.
- Handshake:
  - o_tready = i_tready || !o_tvalid, combinational.
  - fire = i_tvalid && o_tready.
  - When o_tready=1: o_tvalid <= i_tvalid. On fire, o_tdata/o_tuser/o_tlast are loaded.
  - When o_tready=0, all outputs hold.
  - Latency is exactly 1 cycle from fire to the beat appearing on the output. Throughput is 1 beat/cycle with i_tready held high.
- Raster counters (x: clog2(IMG_WIDTH) bits, y: clog2(IMG_HEIGHT) bits) advance only on fire:
  - i_tuser beat: position = (0,0); the next beat is (1,0).
  - Otherwise at x=IMG_WIDTH-1: x=0 and y increments, wrapping to 0 after IMG_HEIGHT-1.
  - Otherwise x increments.
  - i_tlast is not used for counting.
- Metadata double buffer:
  - On i_end_frame: pending <= {i_red_object_valid, i_centroid_x, i_centroid_y}, pending_full=1. Held regardless of fire.
  - On a fire with i_tuser=1 and pending_full=1: active <= pending, pending_full=0.
  - On a fire with i_tuser=1 and pending_full=0: active keeps its value. A frame with no publish repeats the last marker.
  - Simultaneous i_end_frame and tuser fire: active takes the incoming i_* values directly (bypass), and pending_full stays 0.
  - The active update takes effect on the tuser beat itself, i.e. the beat at (0,0) uses the new active values.
  - o_active_valid = active.valid.
- Overlay decision, evaluated on the beat being accepted, using the position of that beat:
  - dx = |x − cx| and dy = |y − cy|, computed unsigned in width+1 bits with no wrap. Arms clip at the image edge and never wrap to the opposite side.
  - hit = (x==cx && dy<=ARM_LEN) || (y==cy && dx<=ARM_LEN).
  - o_tdata <= (i_overlay_en && active.valid && hit) ? MARK_COLOR : i_tdata.
- Centroid values outside the image (cx ≥ IMG_WIDTH or cy ≥ IMG_HEIGHT) are not clamped. Only in-range coordinates can match.

Test Plan:
- Reset then stream one 640x480 frame with pixel = 24'h102030, no publish -> output equals input bit-for-bit, o_tuser only on beat 0, o_tlast every 640th beat, o_active_valid=0.
- Pulse i_end_frame with (320,240,valid=1) mid-frame N, then stream frame N+1 -> frame N unchanged. In frame N+1, exactly 33 pixels = 24'hFF00FF: row 240 cols 312..328 and col 320 rows 232..248. Frame N+2 has no publish -> same 33 pixels.
- Publish (2,1,valid=1) -> marked pixels are row 1 cols 0..10 and col 2 rows 0..9. Nothing marked at cols 630..639 or rows 472..479 (no wrap).
- Random i_tvalid (50%) and random i_tready (30%) over a full frame with a crosshair armed -> no beat lost or duplicated, outputs stable while o_tvalid && !i_tready, overlay positions identical to the no-stall run.
- i_end_frame in the same cycle as the tuser fire with (100,50,valid=1) -> crosshair at (100,50) appears in that same frame. Separately, publish with valid=0 -> next frame is pure pass-through and o_active_valid=0.
- Assert i_rst at line 200 with a crosshair armed -> next cycle o_tvalid=0 and o_active_valid=0. The following frames pass through unmodified until a new publish.
